// File: rtl/ppu_pkg.sv
// Shared PPU types: colour index, RGB triple, palette FSM states and the 2C02 system palette.
package ppu_pkg;

  typedef logic [5:0] color_idx_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {ST_CLEAR, ST_IDLE} pal_state_e;

  // Indexed by the 6-bit NES colour number, 0x00 first.
  localparam logic [23:0] SYS_PALETTE [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

  function automatic logic [7:0] attenuate(input logic [7:0] c);
    return c - (c >> 2);
  endfunction

endpackage

// File: rtl/ppu_sys_palette_rom.sv
// Combinational colour-number to RGB lookup with PPUMASK emphasis and RGB_W scaling.
module ppu_sys_palette_rom
  import ppu_pkg::*;
#(
  parameter int RGB_W = 8
) (
  input  color_idx_t       idx,
  input  logic [2:0]       emphasis,
  input  logic             blank,
  output logic [RGB_W-1:0] red,
  output logic [RGB_W-1:0] green,
  output logic [RGB_W-1:0] blue
);

  rgb_t                  raw;
  logic [2:0][7:0]       ch8;
  logic [2:0][RGB_W-1:0] chw;

  assign raw = SYS_PALETTE[idx];
  assign ch8 = {raw.b, raw.g, raw.r};

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [7:0]       att;
    logic [RGB_W-1:0] sc;
    // A channel dims when any emphasis bit other than its own is set.
    assign att = |(emphasis & ~(3'b001 << c)) ? attenuate(ch8[c]) : ch8[c];
    // MSB-first repeat of the 8-bit value: truncates below 8, replicates above.
    always_comb begin
      sc = '0;
      for (int i = 0; i < RGB_W; i++) sc[RGB_W-1-i] = blank ? 1'b0 : att[7-(i%8)];
    end
    assign chw[c] = sc;
  end

  assign red   = chw[0];
  assign green = chw[1];
  assign blue  = chw[2];

endmodule

// File: rtl/ppu_palette_ram.sv
// PPU palette RAM: CPU read/write port, 2-stage render lookup to RGB, zero-fill walk after reset.
module ppu_palette_ram
  import ppu_pkg::*;
#(
  parameter  int ENTRIES        = 32,
  parameter  int RGB_W          = 8,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int IDX_W          = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_en,
  input  logic             cpu_we,
  input  logic [IDX_W-1:0] cpu_addr,
  input  logic [7:0]       cpu_wdata,
  output logic [7:0]       cpu_rdata,
  output logic             cpu_rvalid,
  input  logic             pix_valid,
  input  logic [IDX_W-1:0] pix_addr,
  input  logic             grayscale,
  input  logic [2:0]       emphasis,
  output logic             rgb_valid,
  output logic [RGB_W-1:0] red,
  output logic [RGB_W-1:0] green,
  output logic [RGB_W-1:0] blue,
  output logic             busy
);

  localparam int               STAGES = 2;
  localparam logic [IDX_W-1:0] BIT4   = IDX_W'(16);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(ENTRIES - 1);

  color_idx_t       mem [ENTRIES];
  pal_state_e       state_q, state_d;
  logic [IDX_W-1:0] clr_cnt;
  logic [IDX_W-1:0] cpu_idx, pix_idx;
  logic             cpu_rd, cpu_wr;
  logic [STAGES:1]  vld_pipe;
  color_idx_t       s1_idx;
  logic             s1_gs, s1_blank;
  logic [2:0]       s1_emph;
  logic [RGB_W-1:0] rom_r, rom_g, rom_b;
  logic             unused_wdata;

  assign unused_wdata = ^cpu_wdata[7:6];
  assign busy   = (state_q == ST_CLEAR);
  assign cpu_rd = cpu_en && !cpu_we;
  assign cpu_wr = cpu_en && cpu_we && !busy;

  // Sprite backdrop mirrors (x0/x4/x8/xC with bit 4) fold onto the background copies;
  // the renderer sends every transparent slot to the universal backdrop.
  assign cpu_idx = (cpu_addr[1:0] == 2'b00) ? (cpu_addr & ~BIT4) : cpu_addr;
  assign pix_idx = (pix_addr[1:0] == 2'b00) ? '0 : pix_addr;

  always_ff @(posedge clk) begin
    if (busy)        mem[clr_cnt] <= '0;
    else if (cpu_wr) mem[cpu_idx] <= cpu_wdata[5:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt <= busy ? clr_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_cnt == LAST) state_d = ST_IDLE;
      ST_IDLE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_rd;
      if (cpu_rd) cpu_rdata <= busy ? 8'h00 : {2'b00, mem[cpu_idx]};
    end
  end

  // S1: entry read (old data on a same-edge write), mode bits, blank flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_idx   <= '0;
      s1_gs    <= 1'b0;
      s1_emph  <= '0;
      s1_blank <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid};
      s1_idx   <= mem[pix_idx];
      s1_gs    <= grayscale;
      s1_emph  <= emphasis;
      s1_blank <= busy;
    end
  end

  ppu_sys_palette_rom #(.RGB_W(RGB_W)) u_rom (
    .idx      (s1_gs ? (s1_idx & 6'h30) : s1_idx),
    .emphasis (s1_emph),
    .blank    (s1_blank),
    .red      (rom_r),
    .green    (rom_g),
    .blue     (rom_b)
  );

  // S2: registered RGB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= rom_r;
      green <= rom_g;
      blue  <= rom_b;
    end
  end

  assign rgb_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_ppu_palette_ram.sv
// Directed bench for ppu_palette_ram: clear walk, mirroring, render pipeline, emphasis, collisions.
module tb_ppu_palette_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_en, cpu_we;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       cpu_rvalid;
  logic       pix_valid;
  logic [4:0] pix_addr;
  logic       grayscale;
  logic [2:0] emphasis;
  logic       rgb_valid;
  logic [7:0] red, green, blue;
  logic       busy;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ppu_palette_ram dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .pix_valid(pix_valid), .pix_addr(pix_addr), .grayscale(grayscale), .emphasis(emphasis),
    .rgb_valid(rgb_valid), .red(red), .green(green), .blue(blue), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    cpu_en = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [4:0] a, output logic [7:0] d, output logic v);
    @(negedge clk);
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(negedge clk);
    d = cpu_rdata; v = cpu_rvalid;
    cpu_en = 1'b0;
  endtask

  task automatic pixel(input logic [4:0] a, input logic gs, input logic [2:0] em,
                       output logic [23:0] c, output logic v);
    @(negedge clk);
    pix_valid = 1'b1; pix_addr = a; grayscale = gs; emphasis = em;
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    c = {red, green, blue}; v = rgb_valid;
    grayscale = 1'b0; emphasis = 3'b000;
  endtask

  // Caller has just released reset on a negedge; counts cycles with busy high.
  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  d;
    logic        v;
    logic [23:0] c;
    int          n;

    rst_n = 1'b0;
    cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    pix_valid = 1'b0; pix_addr = '0; grayscale = 1'b0; emphasis = 3'b000;

    #12;
    chk("rst_rdata", cpu_rdata, 8'h00);
    chk("rst_rvalid", cpu_rvalid, 1'b0);
    chk("rst_rgbvalid", rgb_valid, 1'b0);
    chk("rst_rgb", {red, green, blue}, 24'h000000);
    chk("rst_busy", busy, 1'b1);

    @(negedge clk) rst_n = 1'b1;
    busy_len(n);
    chk("clear_len", n, 32);
    cpu_read(5'h05, d, v);
    chk("rd05_data", d, 8'h00);
    chk("rd05_valid", v, 1'b1);
    @(negedge clk);
    chk("rvalid_pulse", cpu_rvalid, 1'b0);

    // Backdrop mirroring.
    cpu_write(5'h10, 8'h0F);
    cpu_read(5'h00, d, v);
    chk("mirror_rd00", d, 8'h0F);
    cpu_read(5'h10, d, v);
    chk("mirror_rd10", d, 8'h0F);
    pixel(5'h14, 1'b0, 3'b000, c, v);
    chk("pix14_rgb", c, 24'h000000);
    chk("pix14_valid", v, 1'b1);
    cpu_write(5'h00, 8'h30);
    pixel(5'h1C, 1'b0, 3'b000, c, v);
    chk("pix1C_backdrop", c, 24'hFCFCFC);
    cpu_write(5'h14, 8'h2A);
    cpu_read(5'h04, d, v);
    chk("mirror_wr14", d, 8'h2A);

    // Lookup and grayscale; upper write bits are not stored.
    cpu_write(5'h01, 8'hE2);
    cpu_read(5'h01, d, v);
    chk("rd01_6bit", d, 8'h22);
    pixel(5'h01, 1'b0, 3'b000, c, v);
    chk("pix01_rgb", c, 24'h6888FC);
    chk("pix01_valid", v, 1'b1);
    pixel(5'h01, 1'b1, 3'b000, c, v);
    chk("pix01_gray", c, 24'hF8F8F8);

    // Emphasis.
    cpu_write(5'h02, 8'h30);
    pixel(5'h02, 1'b0, 3'b001, c, v);
    chk("emph_red", c, 24'hFCBDBD);
    pixel(5'h02, 1'b0, 3'b010, c, v);
    chk("emph_green", c, 24'hBDFCBD);
    pixel(5'h02, 1'b0, 3'b111, c, v);
    chk("emph_all", c, 24'hBDBDBD);

    // Same-cycle write and render of entry 3, then back-to-back pixel.
    cpu_write(5'h03, 8'h01);
    @(negedge clk);
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h03; cpu_wdata = 8'h16;
    pix_valid = 1'b1; pix_addr = 5'h03;
    @(negedge clk);
    cpu_en = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    chk("coll_old_valid", rgb_valid, 1'b1);
    chk("coll_old_rgb", {red, green, blue}, 24'h0000FC);
    pix_valid = 1'b0;
    @(negedge clk);
    chk("coll_new_valid", rgb_valid, 1'b1);
    chk("coll_new_rgb", {red, green, blue}, 24'hF83800);
    @(negedge clk);
    chk("rgbvalid_drop", rgb_valid, 1'b0);

    // Reset mid-clear: CPU and render behaviour while busy, then restart.
    cpu_write(5'h0B, 8'h2A);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(negedge clk);
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h0B;
    pix_valid = 1'b1; pix_addr = 5'h0B;
    @(negedge clk);
    chk("busy_rd_data", cpu_rdata, 8'h00);
    chk("busy_rd_valid", cpu_rvalid, 1'b1);
    cpu_en = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    chk("busy_pix_valid", rgb_valid, 1'b1);
    chk("busy_pix_black", {red, green, blue}, 24'h000000);
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h05; cpu_wdata = 8'h2A;
    pix_valid = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_rvalid", cpu_rvalid, 1'b1);
    chk("pre_rst_rgbvalid", rgb_valid, 1'b1);
    cpu_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", cpu_rvalid, 1'b0);
    chk("mid_rst_rgbvalid", rgb_valid, 1'b0);
    chk("mid_rst_rdata", cpu_rdata, 8'h00);
    chk("mid_rst_busy", busy, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    busy_len(n);
    chk("reclear_len", n, 32);
    cpu_read(5'h05, d, v);
    chk("busy_wr_dropped", d, 8'h00);
    cpu_read(5'h0B, d, v);
    chk("reclear_0B", d, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/ppu_palette_ram.md
PPU_PALETTE_RAM -- requirements
Module: ppu_palette_ram

Interface
REQ-001 SHALL have parameter ENTRIES, default 32, number of palette entries (power of two, >= 16).
REQ-002 SHALL have parameter RGB_W, default 8, bits per output colour channel.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero-fill all entries after reset.
REQ-004 SHALL have derived localparam IDX_W = clog2(ENTRIES).
REQ-005 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port cpu_en  input  1  CPU access strobe.
REQ-008 SHALL have port cpu_we  input  1  1 = write, 0 = read; qualified by cpu_en.
REQ-009 SHALL have port cpu_addr  input  IDX_W  CPU entry address.
REQ-010 SHALL have port cpu_wdata  input  8  write data; bits [5:0] stored.
REQ-011 SHALL have port cpu_rdata  output  8  read data, {2'b00, entry}.
REQ-012 SHALL have port cpu_rvalid  output  1  read data valid pulse.
REQ-013 SHALL have port pix_valid  input  1  renderer pixel lookup request.
REQ-014 SHALL have port pix_addr  input  IDX_W  renderer palette address.
REQ-015 SHALL have port grayscale  input  1  PPUMASK grayscale mode.
REQ-016 SHALL have port emphasis  input  3  PPUMASK emphasis {blue, green, red}.
REQ-017 SHALL have port rgb_valid  output  1  RGB output valid.
REQ-018 SHALL have ports red, green, blue  output  RGB_W each  pixel colour.
REQ-019 SHALL have port busy  output  1  clear sequence in progress.

Function
REQ-020 SHALL store 6-bit colour indices in ENTRIES flops/RAM words.
REQ-021 SHALL map any address with [1:0]==0 and bit 4 set to the same address with bit 4 cleared, for CPU reads and writes.
REQ-022 SHALL map every render address with [1:0]==0 to entry 0 (universal backdrop).
REQ-023 SHALL return CPU read data one cycle after cpu_en&&!cpu_we, with cpu_rvalid high for exactly that cycle.
REQ-024 SHALL commit CPU writes at the posedge that samples cpu_en&&cpu_we.
REQ-025 SHALL give render reads read-before-write semantics on a same-cycle same-entry collision (old value).
REQ-026 SHALL form the render pipeline: S1 registers entry lookup, grayscale and emphasis; S2 registers RGB. rgb_valid = pix_valid delayed 2 cycles.
REQ-027 SHALL, when grayscale is set, AND the index with 6'h30 before the ROM lookup.
REQ-028 SHALL attenuate a channel (c - (c>>2)) exactly once if any emphasis bit other than its own is set.
REQ-029 SHALL convert indices to RGB using the standard 64-entry NES system palette (e.g. 0x22 -> 6888FC, 0x30 -> FCFCFC, 0x0D -> 000000), scaled by truncation of LSBs or LSB replication to RGB_W.
REQ-030 SHALL use a two-state FSM {CLEAR, IDLE}: CLEAR walks 0..ENTRIES-1, writing 0 for one entry per cycle, then enters IDLE; busy==(state==CLEAR).
REQ-031 SHALL, while busy, drop CPU writes, answer CPU reads with 0 plus cpu_rvalid, and output black with normal rgb_valid timing.
REQ-032 SHALL go directly to IDLE when CLEAR_ON_RESET==0; entry contents are then undefined.
REQ-033 SHALL accept back-to-back requests on both ports every cycle, with no stalls.

Reset
REQ-034 SHALL, on rst_n low, asynchronously force cpu_rdata=0, cpu_rvalid=0, rgb_valid=0, red/green/blue=0, pipeline valids=0, clear counter=0, and state=CLEAR (or IDLE per REQ-032).
REQ-035 SHALL restart the clear walk from entry 0 when reset is asserted mid-clear.

Structure
REQ-036 SHALL place rgb_t, color_idx_t, the FSM state enum and the 64x24 system palette constant in the shared package ppu_pkg.
REQ-037 SHALL implement the index-to-RGB lookup plus emphasis as one sub-module, ppu_sys_palette_rom.

Verification
REQ-038 SHALL verify: release reset -> busy high for exactly 32 cycles; subsequent read of 0x05 -> cpu_rdata 0x00.
REQ-039 SHALL verify: write 0x10 <- 0x0F, read 0x00 -> 0x0F; pix_addr 0x14 -> RGB of entry 0 (000000).
REQ-040 SHALL verify: entry 0x01=0x22, pix_addr 0x01 -> rgb 6888FC two cycles later; with grayscale -> F8F8F8.
REQ-041 SHALL verify: entry 0x02=0x30, emphasis=3'b001 -> red FC, green BD, blue BD; emphasis=3'b111 -> BDBDBD.
REQ-042 SHALL verify: same-cycle CPU write 0x03 <- 0x16 and pix_addr 0x03 (old 0x01) -> pixel 0000FC, next pixel F83800.
REQ-043 SHALL verify: assert rst_n low at clear step 10 -> outputs zero immediately; clear restarts and lasts the full 32 cycles.
